// File: rtl/ex_gpio_port.sv
// Memory-mapped GPIO banks for the 6502 bus: per-bank OUT/DIR/IN/EDGE registers,
// a shared IEN register, synchronised inputs with edge flags and a level interrupt.
module ex_gpio_port #(
   parameter int unsigned address_width = 16,
   parameter int unsigned data_width    = 8,
   parameter int unsigned BaseAddress   = 'h9000,
   parameter int unsigned NumPorts      = 2,
   parameter int unsigned SyncStages    = 2,
   parameter int unsigned EdgeMode      = 2
) (
   input  logic                      clk_i,
   input  logic                      reset_ni,
   input  logic [address_width-1:0]  bus_addr_i,
   input  logic [data_width-1:0]     bus_data_i,
   input  logic                      bus_we_i,
   input  logic                      bus_re_i,
   output logic [data_width-1:0]     bus_data_o,
   output logic                      bus_rvalid_o,
   input  logic [NumPorts*8-1:0]     gpio_i,
   output logic [NumPorts*8-1:0]     gpio_o,
   output logic [NumPorts*8-1:0]     gpio_oe_o,
   output logic                      irq_o
);

   localparam int unsigned GpioW   = NumPorts * 8;
   localparam int unsigned IenOff  = 4 * NumPorts;
   localparam int unsigned ArmCnt  = SyncStages + 1;
   localparam int unsigned CntW    = $clog2(SyncStages + 2);

   logic [GpioW-1:0]         out_q, out_d;
   logic [GpioW-1:0]         dir_q, dir_d;
   logic [GpioW-1:0]         edge_q, edge_d;
   logic [NumPorts-1:0]      ien_q, ien_d;
   logic [GpioW-1:0]         sync_q [SyncStages];
   logic [GpioW-1:0]         prev_q;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic [data_width-1:0]    rdata_q, rdata_d;
   logic                     rvalid_q, rvalid_d;
   logic                     irq_q, irq_d;

   logic [address_width-1:0] off_c;
   logic [2:0]               port_c;
   logic [1:0]               reg_c;
   logic                     hit_port_c;
   logic                     hit_ien_c;
   logic [GpioW-1:0]         in_c;
   logic [GpioW-1:0]         rise_c;
   logic [GpioW-1:0]         fall_c;
   logic [GpioW-1:0]         edge_set_c;
   logic [GpioW-1:0]         w1c_c;
   logic [NumPorts-1:0]      port_flag_c;
   logic                     armed_c;
   logic [data_width-1:0]    rmux_c;

   assign in_c    = sync_q[SyncStages-1];
   assign armed_c = (cnt_q == CntW'(ArmCnt));

   // Address decode relative to the block base; below-base addresses wrap high and miss.
   always_comb begin
      off_c      = bus_addr_i - address_width'(BaseAddress);
      port_c     = off_c[4:2];
      reg_c      = off_c[1:0];
      hit_port_c = (off_c < address_width'(IenOff));
      hit_ien_c  = (off_c == address_width'(IenOff));
   end

   // Read mux over the pre-write register contents.
   always_comb begin
      rmux_c = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (hit_port_c && (port_c == 3'(p))) begin
            case (reg_c)
               2'd0:    rmux_c = out_q[p*8 +: 8];
               2'd1:    rmux_c = dir_q[p*8 +: 8];
               2'd2:    rmux_c = in_c[p*8 +: 8];
               default: rmux_c = edge_q[p*8 +: 8];
            endcase
         end
      end
      if (hit_ien_c) begin
         rmux_c = data_width'(ien_q);
      end
   end

   always_comb begin
      rvalid_d = bus_re_i && (hit_port_c || hit_ien_c);
      rdata_d  = rvalid_d ? rmux_c : '0;
   end

   // Edge qualification is held off until IN and its previous value both hold real samples.
   always_comb begin
      rise_c     = in_c & ~prev_q;
      fall_c     = ~in_c & prev_q;
      edge_set_c = '0;
      if (armed_c) begin
         case (EdgeMode)
            0:       edge_set_c = rise_c;
            1:       edge_set_c = fall_c;
            default: edge_set_c = rise_c | fall_c;
         endcase
      end
      cnt_d = armed_c ? cnt_q : cnt_q + CntW'(1);
   end

   // Register writes; IN is read-only and EDGE is write-1-to-clear with set priority.
   always_comb begin
      out_d = out_q;
      dir_d = dir_q;
      ien_d = ien_q;
      w1c_c = '0;
      if (bus_we_i && hit_port_c) begin
         for (int p = 0; p < NumPorts; p++) begin
            if (port_c == 3'(p)) begin
               case (reg_c)
                  2'd0:    out_d[p*8 +: 8] = bus_data_i[7:0];
                  2'd1:    dir_d[p*8 +: 8] = bus_data_i[7:0];
                  2'd3:    w1c_c[p*8 +: 8] = bus_data_i[7:0];
                  default: ;
               endcase
            end
         end
      end
      if (bus_we_i && hit_ien_c) begin
         ien_d = bus_data_i[NumPorts-1:0];
      end
      edge_d = (edge_q & ~w1c_c) | edge_set_c;
   end

   always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
         port_flag_c[p] = |edge_q[p*8 +: 8];
      end
      irq_d = |(port_flag_c & ien_q);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         out_q    <= '0;
         dir_q    <= '0;
         edge_q   <= '0;
         ien_q    <= '0;
         prev_q   <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         irq_q    <= 1'b0;
         for (int i = 0; i < SyncStages; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         out_q     <= out_d;
         dir_q     <= dir_d;
         edge_q    <= edge_d;
         ien_q     <= ien_d;
         prev_q    <= in_c;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         irq_q     <= irq_d;
         sync_q[0] <= gpio_i;
         for (int i = 1; i < SyncStages; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign gpio_o       = out_q;
   assign gpio_oe_o    = dir_q;
   assign bus_data_o   = rdata_q;
   assign bus_rvalid_o = rvalid_q;
   assign irq_o        = irq_q;

endmodule

// File: tb/tb_ex_gpio_port.sv
// Bench for ex_gpio_port: directed scenarios plus randomized traffic against a
// pin-history reference model of the register map.
module tb_ex_gpio_port;

   localparam int unsigned AW   = 16;
   localparam int unsigned NP   = 2;
   localparam int unsigned S    = 2;
   localparam int unsigned EM   = 2;
   localparam int unsigned BASE = 'h9000;
   localparam int unsigned GW   = NP * 8;
   localparam int unsigned IEN  = BASE + 4 * NP;

   logic          clk = 1'b0;
   logic          reset_ni;
   logic [AW-1:0] bus_addr_i;
   logic [7:0]    bus_data_i;
   logic          bus_we_i;
   logic          bus_re_i;
   logic [7:0]    bus_data_o;
   logic          bus_rvalid_o;
   logic [GW-1:0] gpio_i;
   logic [GW-1:0] gpio_o;
   logic [GW-1:0] gpio_oe_o;
   logic          irq_o;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: pin history since reset (entry i = pins sampled at edge i+1).
   logic [GW-1:0] hist [$];
   logic [GW-1:0] m_out, m_dir, m_edge;
   logic [NP-1:0] m_ien;
   logic          m_irq, m_rvalid;
   logic [7:0]    m_rdata;

   ex_gpio_port #(
      .address_width(AW), .data_width(8), .BaseAddress(BASE),
      .NumPorts(NP), .SyncStages(S), .EdgeMode(EM)
   ) dut (
      .clk_i(clk), .reset_ni(reset_ni),
      .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i),
      .bus_we_i(bus_we_i), .bus_re_i(bus_re_i),
      .bus_data_o(bus_data_o), .bus_rvalid_o(bus_rvalid_o),
      .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   function automatic logic [GW-1:0] pin_at(input int k);
      if (k < 1) return '0;
      return hist[k-1];
   endfunction

   task automatic model_reset();
      m_out = '0; m_dir = '0; m_edge = '0; m_ien = '0;
      m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
      hist.delete();
   endtask

   function automatic void ref_read(input logic [AW-1:0] a, input int m,
                                    output logic ok, output logic [7:0] v);
      int off;
      logic [GW-1:0] in_v;
      off  = int'(a) - int'(BASE);
      in_v = pin_at(m - int'(S));
      ok = 1'b0;
      v  = '0;
      if (off >= 0 && off < int'(4 * NP)) begin
         int p;
         p  = off / 4;
         ok = 1'b1;
         case (off % 4)
            0:       v = m_out[p*8 +: 8];
            1:       v = m_dir[p*8 +: 8];
            2:       v = in_v[p*8 +: 8];
            default: v = m_edge[p*8 +: 8];
         endcase
      end else if (off == int'(4 * NP)) begin
         ok = 1'b1;
         v  = 8'(m_ien);
      end
   endfunction

   // Advance one clock, update the model from the inputs sampled at that edge, settle.
   task automatic step();
      logic          ok;
      logic [7:0]    v;
      logic [GW-1:0] cur, prv, d, w1c;
      int            m, off, p;
      logic          irq_n;
      @(posedge clk);
      if (!reset_ni) begin
         model_reset();
      end else begin
         hist.push_back(gpio_i);
         m = hist.size();
         ref_read(bus_addr_i, m, ok, v);
         m_rvalid = bus_re_i && ok;
         m_rdata  = m_rvalid ? v : 8'h00;
         irq_n = 1'b0;
         for (int q = 0; q < int'(NP); q++)
            if (m_edge[q*8 +: 8] != 8'h00 && m_ien[q]) irq_n = 1'b1;
         m_irq = irq_n;
         d = '0;
         if (m >= int'(S) + 2) begin
            cur = pin_at(m - int'(S));
            prv = pin_at(m - int'(S) - 1);
            case (EM)
               0:       d = cur & ~prv;
               1:       d = ~cur & prv;
               default: d = cur ^ prv;
            endcase
         end
         w1c = '0;
         if (bus_we_i) begin
            off = int'(bus_addr_i) - int'(BASE);
            if (off >= 0 && off < int'(4 * NP)) begin
               p = off / 4;
               case (off % 4)
                  0:       m_out[p*8 +: 8] = bus_data_i;
                  1:       m_dir[p*8 +: 8] = bus_data_i;
                  3:       w1c[p*8 +: 8]   = bus_data_i;
                  default: ;
               endcase
            end else if (off == int'(4 * NP)) begin
               m_ien = bus_data_i[NP-1:0];
            end
         end
         m_edge = (m_edge & ~w1c) | d;
      end
      #1;
   endtask

   task automatic bus_write(input logic [AW-1:0] a, input logic [7:0] dat);
      bus_addr_i = a; bus_data_i = dat; bus_we_i = 1'b1;
      step();
      bus_we_i = 1'b0;
   endtask

   task automatic bus_read(input logic [AW-1:0] a, output logic [7:0] dat, output logic v);
      bus_addr_i = a; bus_re_i = 1'b1;
      step();
      dat = bus_data_o; v = bus_rvalid_o;
      bus_re_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] d; logic v;
      reset_ni = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         gpio_i = GW'($urandom);
         step();
         n_vec++;
         if ({gpio_o, gpio_oe_o, bus_data_o, bus_rvalid_o, irq_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got o=%h oe=%h d=%h rv=%b irq=%b want all 0",
                     gpio_o, gpio_oe_o, bus_data_o, bus_rvalid_o, irq_o);
         end
      end
      gpio_i = '1;
      step();
      reset_ni = 1'b1;
      repeat (S + 4) step();
      bus_read(AW'(BASE + 3), d, v);
      n_vec++;
      if (v !== 1'b1 || d !== 8'h00) begin
         n_err++;
         $display("FAIL reset_edge0: got rv=%b d=%h want rv=1 d=00", v, d);
      end
      n_vec++;
      if (irq_o !== 1'b0) begin
         n_err++;
         $display("FAIL reset_irq: got %b want 0", irq_o);
      end
   endtask

   task automatic test_out_dir();
      bus_write(AW'(BASE), 8'hA5);
      n_vec++;
      if (gpio_o[7:0] !== 8'hA5) begin
         n_err++; $display("FAIL out0_pin: got %h want a5", gpio_o[7:0]);
      end
      bus_write(AW'(BASE + 1), 8'hF0);
      n_vec++;
      if (gpio_oe_o[7:0] !== 8'hF0 || gpio_o !== m_out) begin
         n_err++; $display("FAIL dir0_pin: got oe=%h o=%h want oe=f0 o=%h", gpio_oe_o[7:0], gpio_o, m_out);
      end
      bus_addr_i = AW'(BASE); bus_re_i = 1'b1;
      step();
      bus_re_i = 1'b0;
      n_vec++;
      if (bus_rvalid_o !== 1'b1 || bus_data_o !== 8'hA5) begin
         n_err++; $display("FAIL out0_read: got rv=%b d=%h want rv=1 d=a5", bus_rvalid_o, bus_data_o);
      end
      step();
      n_vec++;
      if (bus_rvalid_o !== 1'b0 || bus_data_o !== 8'h00) begin
         n_err++; $display("FAIL rvalid_pulse: got rv=%b d=%h want rv=0 d=00", bus_rvalid_o, bus_data_o);
      end
   endtask

   task automatic test_edge_irq();
      logic [7:0] d; logic v;
      gpio_i = '0;
      repeat (S + 3) step();
      bus_write(AW'(BASE + 3), 8'hFF);
      bus_write(AW'(BASE + 7), 8'hFF);
      bus_write(AW'(IEN), 8'h01);
      step();
      n_vec++;
      if (irq_o !== 1'b0) begin
         n_err++; $display("FAIL irq_idle: got %b want 0", irq_o);
      end
      gpio_i = GW'(8);
      for (int c = 0; c < int'(S) + 4; c++) begin
         step();
         n_vec++;
         if (irq_o !== m_irq) begin
            n_err++; $display("FAIL irq_rise cyc%0d: got %b want %b", c, irq_o, m_irq);
         end
      end
      n_vec++;
      if (irq_o !== 1'b1) begin
         n_err++; $display("FAIL irq_set: got %b want 1", irq_o);
      end
      bus_read(AW'(BASE + 2), d, v);
      n_vec++;
      if (v !== 1'b1 || d !== 8'h08) begin
         n_err++; $display("FAIL in0_read: got rv=%b d=%h want rv=1 d=08", v, d);
      end
      bus_read(AW'(BASE + 3), d, v);
      n_vec++;
      if (v !== 1'b1 || d !== 8'h08) begin
         n_err++; $display("FAIL edge0_read: got rv=%b d=%h want rv=1 d=08", v, d);
      end
   endtask

   task automatic test_w1c_collision();
      logic [7:0] d; logic v;
      gpio_i = '0;
      step();
      repeat (S - 1) step();
      bus_write(AW'(BASE + 3), 8'h08);
      bus_read(AW'(BASE + 3), d, v);
      n_vec++;
      if (d !== 8'h08 || d !== m_rdata) begin
         n_err++; $display("FAIL w1c_vs_edge: got %h want 08 (model %h)", d, m_rdata);
      end
      bus_write(AW'(BASE + 3), 8'h08);
      n_vec++;
      if (irq_o !== 1'b1) begin
         n_err++; $display("FAIL irq_hold: got %b want 1", irq_o);
      end
      step();
      n_vec++;
      if (irq_o !== 1'b0 || irq_o !== m_irq) begin
         n_err++; $display("FAIL irq_drop: got %b want 0", irq_o);
      end
      bus_read(AW'(BASE + 3), d, v);
      n_vec++;
      if (d !== 8'h00 || v !== 1'b1) begin
         n_err++; $display("FAIL w1c_clear: got rv=%b d=%h want rv=1 d=00", v, d);
      end
   endtask

   task automatic test_unmapped();
      logic [7:0] d; logic v;
      logic [AW-1:0] regs [5];
      regs = '{AW'(BASE), AW'(BASE + 1), AW'(BASE + 4), AW'(BASE + 5), AW'(IEN)};
      bus_read(AW'(IEN + 1), d, v);
      n_vec++;
      if (v !== 1'b0 || d !== 8'h00) begin
         n_err++; $display("FAIL unmapped_hi: got rv=%b d=%h want rv=0 d=00", v, d);
      end
      bus_read(AW'(BASE - 1), d, v);
      n_vec++;
      if (v !== 1'b0 || d !== 8'h00) begin
         n_err++; $display("FAIL unmapped_lo: got rv=%b d=%h want rv=0 d=00", v, d);
      end
      bus_write(AW'(IEN + 1), 8'h5A);
      bus_write(AW'(BASE - 1), 8'h5A);
      bus_write(AW'(BASE + 2), 8'h5A);
      for (int i = 0; i < 5; i++) begin
         bus_read(regs[i], d, v);
         n_vec++;
         if (v !== 1'b1 || d !== m_rdata) begin
            n_err++; $display("FAIL unmapped_write reg%0d: got rv=%b d=%h want rv=1 d=%h", i, v, d, m_rdata);
         end
      end
   endtask

   task automatic test_back_to_back();
      bus_write(AW'(BASE + 4), 8'h3C);
      bus_addr_i = AW'(BASE + 4); bus_data_i = 8'hC3; bus_we_i = 1'b1; bus_re_i = 1'b1;
      step();
      bus_we_i = 1'b0;
      n_vec++;
      if (bus_data_o !== 8'h3C || gpio_o[15:8] !== 8'hC3) begin
         n_err++; $display("FAIL rw_same: got rd=%h pin=%h want rd=3c pin=c3", bus_data_o, gpio_o[15:8]);
      end
      step();
      n_vec++;
      if (bus_rvalid_o !== 1'b1 || bus_data_o !== 8'hC3) begin
         n_err++; $display("FAIL b2b_read1: got rv=%b d=%h want rv=1 d=c3", bus_rvalid_o, bus_data_o);
      end
      bus_addr_i = AW'(BASE + 5);
      step();
      bus_re_i = 1'b0;
      n_vec++;
      if (bus_rvalid_o !== 1'b1 || bus_data_o !== m_rdata) begin
         n_err++; $display("FAIL b2b_read2: got rv=%b d=%h want rv=1 d=%h", bus_rvalid_o, bus_data_o, m_rdata);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) gpio_i = gpio_i ^ GW'($urandom);
         bus_addr_i = AW'(BASE - 2 + $urandom_range(0, 4 * NP + 5));
         bus_data_i = 8'($urandom);
         bus_we_i   = ($urandom_range(0, 2) == 0);
         bus_re_i   = ($urandom_range(0, 1) == 0);
         step();
         n_vec++;
         if (gpio_o !== m_out || gpio_oe_o !== m_dir) begin
            n_err++; $display("FAIL rnd_pins cyc%0d: got o=%h oe=%h want o=%h oe=%h", c, gpio_o, gpio_oe_o, m_out, m_dir);
         end
         n_vec++;
         if (bus_rvalid_o !== m_rvalid || bus_data_o !== m_rdata) begin
            n_err++; $display("FAIL rnd_read cyc%0d: got rv=%b d=%h want rv=%b d=%h", c, bus_rvalid_o, bus_data_o, m_rvalid, m_rdata);
         end
         n_vec++;
         if (irq_o !== m_irq) begin
            n_err++; $display("FAIL rnd_irq cyc%0d: got %b want %b", c, irq_o, m_irq);
         end
      end
      bus_we_i = 1'b0; bus_re_i = 1'b0;
   endtask

   task automatic test_reset_mid_read();
      logic [7:0] d; logic v;
      logic [AW-1:0] regs [3];
      regs = '{AW'(BASE), AW'(BASE + 1), AW'(IEN)};
      bus_write(AW'(BASE), 8'h77);
      bus_write(AW'(BASE + 1), 8'h66);
      bus_write(AW'(IEN), 8'h03);
      bus_addr_i = AW'(BASE); bus_re_i = 1'b1;
      step();
      bus_re_i = 1'b0;
      n_vec++;
      if (bus_rvalid_o !== 1'b1) begin
         n_err++; $display("FAIL pre_reset_rv: got %b want 1", bus_rvalid_o);
      end
      #1 reset_ni = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if ({bus_rvalid_o, bus_data_o, gpio_o, gpio_oe_o} !== '0) begin
         n_err++; $display("FAIL async_reset: got rv=%b d=%h o=%h oe=%h want all 0", bus_rvalid_o, bus_data_o, gpio_o, gpio_oe_o);
      end
      step();
      step();
      reset_ni = 1'b1;
      repeat (2) step();
      for (int i = 0; i < 3; i++) begin
         bus_read(regs[i], d, v);
         n_vec++;
         if (v !== 1'b1 || d !== 8'h00) begin
            n_err++; $display("FAIL post_reset reg%0d: got rv=%b d=%h want rv=1 d=00", i, v, d);
         end
      end
   endtask

   initial begin
      reset_ni   = 1'b0;
      bus_addr_i = '0;
      bus_data_i = '0;
      bus_we_i   = 1'b0;
      bus_re_i   = 1'b0;
      gpio_i     = '0;
      model_reset();
      test_reset();
      test_out_dir();
      test_edge_irq();
      test_w1c_collision();
      test_unmapped();
      test_back_to_back();
      test_random();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
